kernel_window_gen: RTL and testbench

- Successor to the 1-D kernel shift register: builds a KERNEL_H x KERNEL_W pixel window from a stream of pixel columns.
- Each input beat is one column of KERNEL_H vertically aligned pixels, supplied by the upstream line buffers.
- Unlike the previous generation, it:
  - refills at every row boundary (in_last),
  - registers its output with proper valid/ready backpressure,
  - flags rows shorter than the kernel.
- Feeds gradient/HOG cell stages.

---
 rtl/kernel_window_gen.sv | 108 ++++++++++
 tb/tb_kernel_window_gen.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/kernel_window_gen.sv
// Sliding KERNEL_H x KERNEL_W pixel window built from a column stream; refills at
// every row boundary, registered output with valid/ready, flags rows narrower than the kernel.
module kernel_window_gen #(
    parameter int DATA_WIDTH   = 8,
    parameter int KERNEL_W     = 3,
    parameter int KERNEL_H     = 3,
    parameter int COL_WIDTH    = DATA_WIDTH * KERNEL_H,
    parameter int OUTPUT_WIDTH = COL_WIDTH * KERNEL_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [COL_WIDTH-1:0]    in_data,
    input  logic                    in_valid,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic [OUTPUT_WIDTH-1:0] out_data,
    output logic                    out_valid,
    output logic                    out_last,
    input  logic                    out_ready,
    output logic                    short_row_err
);

    localparam int CNT_W = $clog2(KERNEL_W + 1);
    localparam logic [CNT_W:0] KW = (CNT_W + 1)'(KERNEL_W);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_STREAM} state_t;

    state_t                  state_reg, state_next;
    logic [CNT_W-1:0]        cnt_reg, cnt_next;
    logic [OUTPUT_WIDTH-1:0] out_data_reg, out_data_next;
    logic                    out_valid_reg, out_valid_next;
    logic                    out_last_reg, out_last_next;
    logic                    err_reg, err_next;
    logic [OUTPUT_WIDTH-1:0] shift_data;
    logic [CNT_W:0]          cnt_inc;
    logic                    acc;
    logic                    row_full;

    assign in_ready      = out_ready || !out_valid_reg;
    assign acc           = in_valid && in_ready;
    assign cnt_inc       = {1'b0, cnt_reg} + 1'b1;
    assign row_full      = (cnt_inc >= KW);
    assign out_data      = out_data_reg;
    assign out_valid     = out_valid_reg;
    assign out_last      = out_last_reg;
    assign short_row_err = err_reg;

    // Oldest column drops out at j=0; the new column enters at the top slot.
    genvar gi;
    generate
        for (gi = 0; gi < KERNEL_W; gi++) begin : g_shift
            if (gi == KERNEL_W - 1) begin : g_newest
                assign shift_data[gi*COL_WIDTH +: COL_WIDTH] = in_data;
            end else begin : g_older
                assign shift_data[gi*COL_WIDTH +: COL_WIDTH] =
                    out_data_reg[(gi+1)*COL_WIDTH +: COL_WIDTH];
            end
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        out_data_next  = out_data_reg;
        out_valid_next = out_valid_reg;
        out_last_next  = out_last_reg;
        err_next       = 1'b0;
        if (acc) begin
            out_data_next  = shift_data;
            out_valid_next = row_full;
            out_last_next  = in_last && row_full;
            err_next       = in_last && !row_full;
            if (in_last) begin
                // Row end always restarts the fill, so no window straddles two rows.
                cnt_next   = '0;
                state_next = S_IDLE;
            end else if (row_full) begin
                cnt_next   = KW[CNT_W-1:0];
                state_next = S_STREAM;
            end else begin
                cnt_next   = cnt_inc[CNT_W-1:0];
                state_next = S_FILL;
            end
        end else if (out_ready) begin
            out_valid_next = 1'b0;
            out_last_next  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            out_data_reg  <= out_data_next;
            out_valid_reg <= out_valid_next;
            out_last_reg  <= out_last_next;
            err_reg       <= err_next;
        end
    end

endmodule

// File: tb/tb_kernel_window_gen.sv
// Directed table-driven bench for kernel_window_gen (3x3 default instance plus a 1-wide, 2-high instance).
module tb_kernel_window_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] in_data = '0;
    logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
    logic        in_ready, out_valid, out_last, short_row_err;
    logic [71:0] out_data;

    logic [15:0] in1_data = '0;
    logic        in1_valid = 1'b0, in1_last = 1'b0, out1_ready = 1'b1;
    logic        in1_ready, out1_valid, out1_last, err1;
    logic [15:0] out1_data;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    kernel_window_gen dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
        .out_ready(out_ready), .short_row_err(short_row_err)
    );

    kernel_window_gen #(.DATA_WIDTH(8), .KERNEL_W(1), .KERNEL_H(2)) dut1 (
        .clk(clk), .rst(rst), .in_data(in1_data), .in_valid(in1_valid), .in_last(in1_last),
        .in_ready(in1_ready), .out_data(out1_data), .out_valid(out1_valid), .out_last(out1_last),
        .out_ready(out1_ready), .short_row_err(err1)
    );

    typedef struct {
        logic       vld;
        logic       last;
        logic [7:0] b;
        logic       ordy;
        logic       e_rdy;
        logic       e_ov;
        logic       e_ol;
        logic       e_err;
        logic [7:0] wa, wb, wc;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic vld, logic last, logic [7:0] b, logic ordy, logic e_rdy,
                                logic e_ov, logic e_ol, logic e_err,
                                logic [7:0] wa, logic [7:0] wb, logic [7:0] wc);
        vec_t v;
        v.vld = vld; v.last = last; v.b = b; v.ordy = ordy; v.e_rdy = e_rdy;
        v.e_ov = e_ov; v.e_ol = e_ol; v.e_err = e_err; v.wa = wa; v.wb = wb; v.wc = wc;
        return v;
    endfunction

    function automatic logic [71:0] win(logic [7:0] a, logic [7:0] b, logic [7:0] c);
        return {c, c, c, b, b, b, a, a, a};
    endfunction

    task automatic chk(string name, logic [71:0] act, logic [71:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Drive one vector just after an edge, check in_ready, then check registered outputs after the next edge.
    task automatic apply(vec_t v, int idx);
        in_valid  = v.vld;
        in_last   = v.last;
        in_data   = {v.b, v.b, v.b};
        out_ready = v.ordy;
        #1;
        chk($sformatf("in_ready[%0d]", idx), 72'(in_ready), 72'(v.e_rdy));
        @(posedge clk);
        #1;
        chk($sformatf("out_valid[%0d]", idx), 72'(out_valid), 72'(v.e_ov));
        chk($sformatf("out_last[%0d]", idx), 72'(out_last), 72'(v.e_ol));
        chk($sformatf("short_row_err[%0d]", idx), 72'(short_row_err), 72'(v.e_err));
        if (v.e_ov)
            chk($sformatf("out_data[%0d]", idx), out_data, win(v.wa, v.wb, v.wc));
        $display("vec %0d: vld=%0b last=%0b col=%02h ordy=%0b -> ov=%0b ol=%0b err=%0b data=%h",
                 idx, v.vld, v.last, v.b, v.ordy, out_valid, out_last, short_row_err, out_data);
    endtask

    initial begin
        // Full 3-column row of 5 beats, ready always high
        vq.push_back(mk(1,0,8'h01,1, 1,0,0,0, 0,0,0));
        vq.push_back(mk(1,0,8'h02,1, 1,0,0,0, 0,0,0));
        vq.push_back(mk(1,0,8'h03,1, 1,1,0,0, 8'h01,8'h02,8'h03));
        vq.push_back(mk(1,0,8'h04,1, 1,1,0,0, 8'h02,8'h03,8'h04));
        vq.push_back(mk(1,1,8'h05,1, 1,1,1,0, 8'h03,8'h04,8'h05));
        vq.push_back(mk(0,0,8'h00,1, 1,0,0,0, 0,0,0));
        // Back-to-back rows: second row must start clean
        vq.push_back(mk(1,0,8'h01,1, 1,0,0,0, 0,0,0));
        vq.push_back(mk(1,0,8'h02,1, 1,0,0,0, 0,0,0));
        vq.push_back(mk(1,0,8'h03,1, 1,1,0,0, 8'h01,8'h02,8'h03));
        vq.push_back(mk(1,1,8'h04,1, 1,1,1,0, 8'h02,8'h03,8'h04));
        vq.push_back(mk(1,0,8'h11,1, 1,0,0,0, 0,0,0));
        vq.push_back(mk(1,0,8'h12,1, 1,0,0,0, 0,0,0));
        vq.push_back(mk(1,1,8'h13,1, 1,1,1,0, 8'h11,8'h12,8'h13));
        vq.push_back(mk(0,0,8'h00,1, 1,0,0,0, 0,0,0));
        // Backpressure: window held for 4 stalled cycles, column 0x34 waits
        vq.push_back(mk(1,0,8'h31,1, 1,0,0,0, 0,0,0));
        vq.push_back(mk(1,0,8'h32,1, 1,0,0,0, 0,0,0));
        vq.push_back(mk(1,0,8'h33,1, 1,1,0,0, 8'h31,8'h32,8'h33));
        for (int i = 0; i < 4; i++)
            vq.push_back(mk(1,0,8'h34,0, 0,1,0,0, 8'h31,8'h32,8'h33));
        vq.push_back(mk(1,0,8'h34,1, 1,1,0,0, 8'h32,8'h33,8'h34));
        vq.push_back(mk(1,1,8'h35,1, 1,1,1,0, 8'h33,8'h34,8'h35));
        vq.push_back(mk(0,0,8'h00,1, 1,0,0,0, 0,0,0));
        // Short row then a normal row
        vq.push_back(mk(1,0,8'h07,1, 1,0,0,0, 0,0,0));
        vq.push_back(mk(1,1,8'h08,1, 1,0,0,1, 0,0,0));
        vq.push_back(mk(0,0,8'h00,1, 1,0,0,0, 0,0,0));
        vq.push_back(mk(1,0,8'h21,1, 1,0,0,0, 0,0,0));
        vq.push_back(mk(1,0,8'h22,1, 1,0,0,0, 0,0,0));
        vq.push_back(mk(1,1,8'h23,1, 1,1,1,0, 8'h21,8'h22,8'h23));
        vq.push_back(mk(0,0,8'h00,1, 1,0,0,0, 0,0,0));

        // Reset state
        #12;
        chk("rst_out_valid", 72'(out_valid), 72'(0));
        chk("rst_out_last", 72'(out_last), 72'(0));
        chk("rst_err", 72'(short_row_err), 72'(0));
        chk("rst_out_data", out_data, 72'(0));
        chk("rst_in_ready", 72'(in_ready), 72'(1));
        @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (vq[i]) apply(vq[i], i);

        // Mid-row asynchronous reset
        apply(mk(1,0,8'h41,1, 1,0,0,0, 0,0,0), 100);
        apply(mk(1,0,8'h42,1, 1,0,0,0, 0,0,0), 101);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_out_data", out_data, 72'(0));
        chk("mid_rst_out_valid", 72'(out_valid), 72'(0));
        chk("mid_rst_out_last", 72'(out_last), 72'(0));
        chk("mid_rst_err", 72'(short_row_err), 72'(0));
        $display("mid-row reset: data=%h ov=%0b", out_data, out_valid);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        apply(mk(1,0,8'h43,1, 1,0,0,0, 0,0,0), 102);
        apply(mk(1,0,8'h44,1, 1,0,0,0, 0,0,0), 103);
        apply(mk(1,0,8'h45,1, 1,1,0,0, 8'h43,8'h44,8'h45), 104);
        apply(mk(0,0,8'h00,1, 1,0,0,0, 0,0,0), 105);

        // KERNEL_W=1, KERNEL_H=2 instance
        in1_valid = 1'b1; in1_last = 1'b0; in1_data = 16'hAABB;
        @(posedge clk);
        #1;
        chk("w1_valid_a", 72'(out1_valid), 72'(1));
        chk("w1_data_a", 72'(out1_data), 72'(16'hAABB));
        chk("w1_last_a", 72'(out1_last), 72'(0));
        chk("w1_err_a", 72'(err1), 72'(0));
        $display("w1 beat AABB: ov=%0b data=%h err=%0b", out1_valid, out1_data, err1);
        in1_last = 1'b1; in1_data = 16'hCCDD;
        @(posedge clk);
        #1;
        chk("w1_valid_b", 72'(out1_valid), 72'(1));
        chk("w1_data_b", 72'(out1_data), 72'(16'hCCDD));
        chk("w1_last_b", 72'(out1_last), 72'(1));
        chk("w1_err_b", 72'(err1), 72'(0));
        $display("w1 beat CCDD last: ov=%0b ol=%0b data=%h err=%0b", out1_valid, out1_last, out1_data, err1);
        in1_valid = 1'b0; in1_last = 1'b0;
        @(posedge clk);
        #1;
        chk("w1_valid_idle", 72'(out1_valid), 72'(0));
        chk("w1_err_idle", 72'(err1), 72'(0));
        $display("w1 idle: ov=%0b err=%0b", out1_valid, err1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
